// File: rtl/rr_arb2_stage_pkg.sv
// Shared channel and output-stage state encodings for the two-channel arbiter
// and the mux-stage logic downstream of it.
package rr_arb2_stage_pkg;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic ch_e other_ch(input ch_e c);
    return (c == CH_A) ? CH_B : CH_A;
  endfunction

endpackage

// File: rtl/rr_arb2_stage_grant.sv
// Combinational two-way grant with round-robin priority register and, when
// ARB_PKT_LOCK_EN is defined, a packet lock that pins the grant until last.
module arb2_grant
  import rr_arb2_stage_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  input  logic accept,
`ifdef ARB_PKT_LOCK_EN
  input  logic accept_last,
`endif
  output ch_e  grant
);

  ch_e prio;
`ifdef ARB_PKT_LOCK_EN
  logic lock;
  ch_e  lock_ch;
`endif

  always_comb begin
    if (a_valid && !b_valid)      grant = CH_A;
    else if (b_valid && !a_valid) grant = CH_B;
    else                          grant = prio;
`ifdef ARB_PKT_LOCK_EN
    // A locked packet owns the output even while its channel idles.
    if (lock) grant = lock_ch;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= ch_e'(FIRST_PRIO);
`ifdef ARB_PKT_LOCK_EN
      lock    <= 1'b0;
      lock_ch <= CH_A;
`endif
    end else if (accept) begin
`ifdef ARB_PKT_LOCK_EN
      lock    <= !accept_last;
      lock_ch <= grant;
      if (accept_last) prio <= other_ch(grant);
`else
      prio <= other_ch(grant);
`endif
    end
  end

endmodule

// File: rtl/rr_arb2_stage.sv
// Two-channel round-robin stream arbiter with a one-entry registered output
// stage driving out_sel for the downstream 2:1 mux. Option: ARB_PKT_LOCK_EN.
module rr_arb2_stage
  import rr_arb2_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_last
);

  state_e state, state_nxt;
  ch_e    grant;
  logic   load_en;
  logic   a_acc, b_acc, accept;

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  assign a_ready   = load_en && (grant == CH_A) && !rst;
  assign b_ready   = load_en && (grant == CH_B) && !rst;
  assign a_acc     = a_valid && a_ready;
  assign b_acc     = b_valid && b_ready;
  assign accept    = a_acc || b_acc;

  arb2_grant #(
    .FIRST_PRIO (FIRST_PRIO)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .b_valid     (b_valid),
    .accept      (accept),
`ifdef ARB_PKT_LOCK_EN
    .accept_last (a_acc ? a_last : b_last),
`endif
    .grant       (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Payload holds its last value when empty; only out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= CH_A;
      out_last <= 1'b0;
    end else if (accept) begin
      out_data <= a_acc ? a_data : b_data;
      out_last <= a_acc ? a_last : b_last;
      out_sel  <= grant;
    end
  end

endmodule
